// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester-side and slave-side signals of the shared byte bus.
// Pure wiring, no latency.
// Backpressure is carried by the 4-phase ready lines; the master modport is the environment and the slave modport is the arbiter.
interface mem_bus_arbiter_if #(
  parameter int N  = 2,
  parameter int AW = 16,
  parameter int DW = 8
);
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   req_rdata;
  logic [N-1:0]    req_lock;
  logic            m_valid;
  logic            m_write;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic            m_ready;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    grant;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_lock, m_ready, m_rdata,
    input  req_ready, req_rdata, m_valid, m_write, m_addr, m_wdata, grant
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_lock, m_ready, m_rdata,
    output req_ready, req_rdata, m_valid, m_write, m_addr, m_wdata, grant
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one 4-phase byte bus among N requesters; optional lock via MEM_BUS_ARBITER_LOCK_EN.
// Latency: grant one cycle after req_valid; data path is purely combinational.
// Backpressure: non-granted requesters see req_ready=0 and hold valid; grant is held for a full handshake.
module mem_bus_arbiter #(
  parameter int N  = 2,
  parameter int AW = 16,
  parameter int DW = 8
) (
  input logic clk,
  input logic rst,
  mem_bus_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, REQ, ACK, REL, LOCKED} state_t;

  state_t        state;
  logic [N-1:0]  grant_q;
  logic [IW-1:0] gidx;
  logic [IW-1:0] rr;
  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic          own_valid;
  logic [IW-1:0] rr_nxt;

  assign own_valid = |(bus.req_valid & grant_q);
  assign rr_nxt    = (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;

  // First valid requester at or after the round-robin pointer, wrapping modulo N.
  always_comb begin
    int j;
    pick_vld = 1'b0;
    pick_idx = '0;
    j = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(rr) + i) % N;
      if (bus.req_valid[j]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  // Forward the granted requester's signals to the slave; everything is 0 while no grant is held.
  always_comb begin
    bus.m_valid = 1'b0;
    bus.m_write = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_q[k]) begin
        bus.m_valid = bus.req_valid[k];
        bus.m_write = bus.req_write[k];
        bus.m_addr  = bus.req_addr[k*AW +: AW];
        bus.m_wdata = bus.req_wdata[k*DW +: DW];
      end
    end
  end

  assign bus.req_ready = {N{bus.m_ready}} & grant_q;
  assign bus.req_rdata = bus.m_rdata;
  assign bus.grant     = grant_q;

`ifndef MEM_BUS_ARBITER_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^bus.req_lock;
`endif

  // Grant FSM: arbitrate in IDLE, follow the slave handshake, release once ready falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      gidx    <= '0;
      rr      <= '0;
    end else begin
      case (state)
        // A slave still holding ready (e.g. after reset) must finish before a new grant.
        IDLE: if (!bus.m_ready && pick_vld) begin
          grant_q <= N'(1) << pick_idx;
          gidx    <= pick_idx;
          state   <= REQ;
        end
        REQ: if (bus.m_ready) state <= ACK;
        ACK: if (!own_valid) state <= REL;
        REL: if (!bus.m_ready) begin
`ifdef MEM_BUS_ARBITER_LOCK_EN
          if (bus.req_lock[gidx]) begin
            state <= LOCKED;
          end else begin
            grant_q <= '0;
            rr      <= rr_nxt;
            state   <= IDLE;
          end
`else
          grant_q <= '0;
          rr      <= rr_nxt;
          state   <= IDLE;
`endif
        end
`ifdef MEM_BUS_ARBITER_LOCK_EN
        // Grant kept for the locking requester only; its next valid starts a new handshake.
        LOCKED: if (own_valid) state <= REQ;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with N=2: vector table plus multi-cycle sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Slave ready is driven directly by the bench to place each handshake phase exactly.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;
  logic [7:0] mem [16];

  mem_bus_arbiter_if #(.N(2), .AW(16), .DW(8)) bus ();

  mem_bus_arbiter #(.N(2), .AW(16), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Byte memory standing in for the slave's storage.
  always @(posedge clk) begin
    if (bus.m_valid && bus.m_ready && bus.m_write) mem[bus.m_addr[3:0]] <= bus.m_wdata;
  end

  typedef struct {
    logic [1:0]  rv;
    logic [1:0]  wr;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        mr;
    logic [7:0]  rd;
    logic [1:0]  eg;
    logic        emv;
    logic        emw;
    logic [15:0] ema;
    logic [7:0]  emd;
    logic [1:0]  err;
    logic [7:0]  erd;
  } vec_t;

  vec_t tbl [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    else passed++;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_lock  = '0;
    bus.m_ready   = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // One full transaction for requester k while other requests stay pending.
  task automatic serve(input int k, input bit hold, input string nm);
    int n;
    logic [1:0] oh;
    oh = 2'b01 << k;
    step();
    n = 0;
    while (bus.grant == 2'b00 && n < 4) begin
      step();
      n++;
    end
    chk({nm, " grant"}, 64'(bus.grant), 64'(oh));
    bus.m_ready = 1'b1;
    bus.m_rdata = 8'h40 + 8'(k);
    step();
    chk({nm, " ready"}, 64'(bus.req_ready), 64'(oh));
    bus.req_valid[k] = 1'b0;
    step();
    bus.m_ready = 1'b0;
    step();
    chk({nm, " release"}, 64'(bus.grant), hold ? 64'(oh) : 64'd0);
    bus.req_valid[k] = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //            rv     wr     a0        a1        d0     d1     mr    rd      eg     emv   emw   ema       emd    err    erd
    tbl[0]  = '{2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 16'h0000, 8'h00, 2'b00, 8'h00};
    tbl[1]  = '{2'b01, 2'b00, 16'h1000, 16'h0000, 8'h00, 8'h00, 1'b0, 8'h00, 2'b01, 1'b1, 1'b0, 16'h1000, 8'h00, 2'b00, 8'h00};
    tbl[2]  = '{2'b01, 2'b00, 16'h1000, 16'h0000, 8'h00, 8'h00, 1'b1, 8'h5A, 2'b01, 1'b1, 1'b0, 16'h1000, 8'h00, 2'b01, 8'h5A};
    tbl[3]  = '{2'b00, 2'b00, 16'h1000, 16'h0000, 8'h00, 8'h00, 1'b1, 8'h5A, 2'b01, 1'b0, 1'b0, 16'h1000, 8'h00, 2'b01, 8'h5A};
    tbl[4]  = '{2'b00, 2'b00, 16'h1000, 16'h0000, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 16'h0000, 8'h00, 2'b00, 8'h00};
    tbl[5]  = '{2'b10, 2'b10, 16'h1000, 16'h1004, 8'h00, 8'hA5, 1'b0, 8'h00, 2'b10, 1'b1, 1'b1, 16'h1004, 8'hA5, 2'b00, 8'h00};
    tbl[6]  = '{2'b10, 2'b10, 16'h1000, 16'h1004, 8'h00, 8'hA5, 1'b1, 8'h00, 2'b10, 1'b1, 1'b1, 16'h1004, 8'hA5, 2'b10, 8'h00};
    tbl[7]  = '{2'b00, 2'b00, 16'h1000, 16'h1004, 8'h00, 8'hA5, 1'b1, 8'h00, 2'b10, 1'b0, 1'b0, 16'h1004, 8'hA5, 2'b10, 8'h00};
    tbl[8]  = '{2'b00, 2'b00, 16'h1000, 16'h1004, 8'h00, 8'hA5, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 16'h0000, 8'h00, 2'b00, 8'h00};
    tbl[9]  = '{2'b11, 2'b00, 16'h2000, 16'h2001, 8'h11, 8'h22, 1'b0, 8'h00, 2'b01, 1'b1, 1'b0, 16'h2000, 8'h11, 2'b00, 8'h00};
    tbl[10] = '{2'b11, 2'b00, 16'h2000, 16'h2001, 8'h11, 8'h22, 1'b1, 8'h33, 2'b01, 1'b1, 1'b0, 16'h2000, 8'h11, 2'b01, 8'h33};
    tbl[11] = '{2'b10, 2'b00, 16'h2000, 16'h2001, 8'h11, 8'h22, 1'b1, 8'h33, 2'b01, 1'b0, 1'b0, 16'h2000, 8'h11, 2'b01, 8'h33};
    tbl[12] = '{2'b10, 2'b00, 16'h2000, 16'h2001, 8'h11, 8'h22, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 16'h0000, 8'h00, 2'b00, 8'h00};
    tbl[13] = '{2'b10, 2'b00, 16'h2000, 16'h2001, 8'h11, 8'h22, 1'b0, 8'h00, 2'b10, 1'b1, 1'b0, 16'h2001, 8'h22, 2'b00, 8'h00};

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.m_rdata   = '0;
    #1;
    do_reset();
    chk("reset outputs",
        64'({bus.grant, bus.req_ready, bus.m_valid, bus.m_write, bus.m_addr, bus.m_wdata}), 64'd0);

    // Single read, write pass-through and two-way contention, cycle by cycle.
    for (int i = 0; i < 14; i++) begin
      bus.req_valid = tbl[i].rv;
      bus.req_write = tbl[i].wr;
      bus.req_addr  = {tbl[i].a1, tbl[i].a0};
      bus.req_wdata = {tbl[i].d1, tbl[i].d0};
      bus.m_ready   = tbl[i].mr;
      bus.m_rdata   = tbl[i].rd;
      step();
      chk($sformatf("vec%0d ctl", i),
          64'({bus.grant, bus.req_ready, bus.m_valid, bus.m_write}),
          64'({tbl[i].eg, tbl[i].err, tbl[i].emv, tbl[i].emw}));
      chk($sformatf("vec%0d dat", i),
          64'({bus.m_addr, bus.m_wdata, bus.req_rdata}),
          64'({tbl[i].ema, tbl[i].emd, tbl[i].erd}));
    end
    chk("mem byte 0x1004", 64'(mem[4]), 64'h00A5);

    // Both requesters permanently valid: grants alternate 0,1,0,1.
    do_reset();
    bus.req_write = '0;
    bus.req_valid = 2'b11;
    for (int p = 0; p < 4; p++) begin
      serve(0, 1'b0, $sformatf("alt%0d r0", p));
      serve(1, 1'b0, $sformatf("alt%0d r1", p));
    end

    // Slow slave: ready after 5 cycles, master holds valid 3 cycles past ready.
    do_reset();
    bus.req_valid = 2'b11;
    step();
    chk("slow grant", 64'(bus.grant), 64'h1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("slow req wait%0d", c), 64'({bus.grant, bus.req_ready, bus.m_valid}), 64'({2'b01, 2'b00, 1'b1}));
    end
    bus.m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("slow ack hold%0d", c), 64'({bus.grant, bus.req_ready, bus.m_valid}), 64'({2'b01, 2'b01, 1'b1}));
    end
    bus.req_valid[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("slow rel hold%0d", c), 64'({bus.grant, bus.m_valid}), 64'({2'b01, 1'b0}));
    end
    bus.m_ready = 1'b0;
    step();
    chk("slow release", 64'(bus.grant), 64'h0);
    step();
    chk("slow next grant", 64'(bus.grant), 64'h2);

    // Reset in ACK with ready still high; re-grant waits for ready to fall.
    do_reset();
    bus.req_valid = 2'b01;
    step();
    bus.m_ready = 1'b1;
    step();
    chk("pre-reset ack", 64'(bus.req_ready), 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("reset mid-ack", 64'({bus.grant, bus.req_ready, bus.m_valid, bus.m_addr}), 64'd0);
    step();
    step();
    chk("no grant while ready", 64'(bus.grant), 64'h0);
    bus.m_ready = 1'b0;
    step();
    chk("grant after ready low", 64'(bus.grant), 64'h1);

    // Lock sequence: requester 0 asks for lock on its first transaction only.
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_lock  = 2'b01;
`ifdef MEM_BUS_ARBITER_LOCK_EN
    serve(0, 1'b1, "lock r0a");
    bus.req_lock = 2'b00;
    serve(0, 1'b0, "lock r0b");
    serve(1, 1'b0, "lock r1");
`else
    serve(0, 1'b0, "nolock r0a");
    serve(1, 1'b0, "nolock r1");
    serve(0, 1'b0, "nolock r0b");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
